// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch/decode sequencer: default widths,
// control-flow opcodes and the sequencer state encoding.
package fetch_sequencer_pkg;

    localparam int AW_DEF  = 4;
    localparam int DW_DEF  = 8;
    localparam int OPW_DEF = 4;

    localparam logic [3:0] OP_JMP = 4'hB;
    localparam logic [3:0] OP_JZ  = 4'hC;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        HALT
    } state_t;

endpackage

// File: rtl/fetch_sequencer_pc_reg.sv
// Program counter: load has priority over increment, wraps modulo 2^AW,
// synchronous active-high reset to zero.
module fetch_sequencer_pc_reg #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          inc,
    input  logic [AW-1:0] target,
    output logic [AW-1:0] pc
);

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= '0;
        end else if (load) begin
            pc <= target;
        end else if (inc) begin
            pc <= pc + AW'(1);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/decode sequencer: owns the PC, latches instructions, resolves
// JMP/JZ/HLT locally and hands other opcodes to the datapath.
// Optional build macro SINGLE_STEP_EN adds the step input.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int AW  = AW_DEF,
    parameter int DW  = DW_DEF,
    parameter int OPW = OPW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
`ifdef SINGLE_STEP_EN
    input  logic              step,
`endif
    output logic [AW-1:0]     mem_addr,
    input  logic [DW-1:0]     mem_data,
    output logic [OPW-1:0]    opcode,
    output logic [DW-OPW-1:0] operand,
    output logic              exec_valid,
    input  logic              exec_ready,
    input  logic              zero_flag,
    output logic [AW-1:0]     pc,
    output logic              halted
);

    state_t         state, state_next;
    logic [DW-1:0]  ir;
    logic           ir_load;
    logic           pc_load;
    logic           pc_inc;
    logic           advance;

`ifdef SINGLE_STEP_EN
    assign advance = run & step;
`else
    assign advance = run;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ir    <= '0;
        end else begin
            state <= state_next;
            if (ir_load) begin
                ir <= mem_data;
            end
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
        state_next = state;
        ir_load    = 1'b0;
        pc_load    = 1'b0;
        pc_inc     = 1'b0;
        case (state)
            IDLE: begin
                if (advance) state_next = FETCH;
            end
            FETCH: begin
                ir_load    = 1'b1;
                state_next = DECODE;
            end
            DECODE: begin
                if (opcode == OPW'(OP_JMP)) begin
                    pc_load    = 1'b1;
                    state_next = advance ? FETCH : IDLE;
                end else if (opcode == OPW'(OP_JZ)) begin
                    pc_load    = zero_flag;
                    pc_inc     = ~zero_flag;
                    state_next = advance ? FETCH : IDLE;
                end else if (opcode == OPW'(OP_HLT)) begin
                    state_next = HALT;
                end else begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (exec_ready) begin
                    pc_inc     = 1'b1;
                    state_next = advance ? FETCH : IDLE;
                end
            end
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    fetch_sequencer_pc_reg #(.AW(AW)) u_pc_reg (
        .clk    (clk),
        .rst    (rst),
        .load   (pc_load),
        .inc    (pc_inc),
        .target (AW'(operand)),
        .pc     (pc)
    );

    assign opcode     = ir[DW-1:DW-OPW];
    assign operand    = ir[DW-OPW-1:0];
    assign mem_addr   = pc;
    assign exec_valid = (state == EXEC);
    assign halted     = (state == HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed control-flow steps
// followed by random programs checked against an instruction-level model.
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       rst, run, step, exec_ready, zero_flag;
    logic [3:0] mem_addr, opcode, operand, pc;
    logic [7:0] mem_data;
    logic       exec_valid, halted;
    logic [7:0] mem [16];

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    assign mem_data = mem[mem_addr];

    fetch_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
`ifdef SINGLE_STEP_EN
        .step       (step),
`endif
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .opcode     (opcode),
        .operand    (operand),
        .exec_valid (exec_valid),
        .exec_ready (exec_ready),
        .zero_flag  (zero_flag),
        .pc         (pc),
        .halted     (halted)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Instruction-level model: walk control flow from m_pc until a datapath op.
    logic [3:0] m_pc;
    logic       m_zero;

    task automatic next_exec(output logic [3:0] e_pc, output logic [7:0] e_ins);
        e_pc  = m_pc;
        e_ins = mem[m_pc];
        for (int n = 0; n < 32; n++) begin
            e_pc  = m_pc;
            e_ins = mem[m_pc];
            if (e_ins[7:4] == 4'hB)      m_pc = e_ins[3:0];
            else if (e_ins[7:4] == 4'hC) m_pc = m_zero ? e_ins[3:0] : m_pc + 4'd1;
            else break;
        end
        m_pc = e_pc + 4'd1;
    endtask

    logic [3:0] e_pc, exp_pc_next;
    logic [7:0] e_ins;
    logic       pend, rdy;
    int         seen;
    int         op;

    initial begin
        foreach (mem[i]) mem[i] = 8'h00;
        mem[0]  = 8'h08; mem[1] = 8'h19; mem[2] = 8'hB9; mem[9] = 8'hB3;
        mem[3]  = 8'hC5; mem[5] = 8'hB7; mem[7] = 8'hC2; mem[8] = 8'hBF;
        mem[15] = 8'h10;
        rst = 1'b1; run = 1'b0; step = 1'b1; exec_ready = 1'b0; zero_flag = 1'b0;

        // Reset and first datapath instruction
        tick(); tick();
        check("rst_pc", int'(pc), 0);
        check("rst_valid", int'(exec_valid), 0);
        check("rst_halted", int'(halted), 0);
        check("rst_opcode", int'(opcode), 0);
        check("rst_operand", int'(operand), 0);
        rst = 1'b0; run = 1'b1; exec_ready = 1'b1;
        tick(); tick(); tick();
        check("start_valid", int'(exec_valid), 1);
        check("start_opcode", int'(opcode), 0);
        check("start_operand", int'(operand), 8);
        tick();
        check("start_pc_inc", int'(pc), 1);
        check("start_valid_drop", int'(exec_valid), 0);

        // Backpressure
        exec_ready = 1'b0;
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", int'(exec_valid), 1);
            check("bp_opcode", int'(opcode), 1);
            check("bp_operand", int'(operand), 9);
            check("bp_pc", int'(pc), 1);
            tick();
        end
        exec_ready = 1'b1;
        tick();
        check("bp_pc_inc", int'(pc), 2);

        // Jumps, JZ taken / not taken, wrap
        zero_flag = 1'b1;
        tick(); check("jmp_no_valid", int'(exec_valid), 0);
        tick(); check("jmp_pc9", int'(pc), 9);
        tick(); check("jmp_no_valid2", int'(exec_valid), 0);
        tick(); check("jmp_pc3", int'(pc), 3);
        tick(); tick(); check("jz_taken", int'(pc), 5);
        zero_flag = 1'b0;
        tick(); tick(); check("jmp_pc7", int'(pc), 7);
        tick(); tick(); check("jz_not_taken_pc8", int'(pc), 8);
        tick(); tick(); check("jmp_pc15", int'(pc), 15);
        tick(); tick();
        check("wrap_valid", int'(exec_valid), 1);
        check("wrap_opcode", int'(opcode), 1);
        tick(); check("wrap_pc0", int'(pc), 0);

        // JZ not taken at pc=4
        rst = 1'b1; mem[0] = 8'hB4; mem[4] = 8'hC5;
        tick();
        rst = 1'b0;
        tick(); tick(); tick(); check("jmp_pc4", int'(pc), 4);
        tick(); tick(); check("jz_inc_pc5", int'(pc), 5);

        // Halt
        rst = 1'b1; mem[0] = 8'hF0;
        tick();
        rst = 1'b0;
        tick(); tick(); tick();
        for (int i = 0; i < 6; i++) begin
            check("halt_flag", int'(halted), 1);
            check("halt_pc", int'(pc), 0);
            check("halt_valid", int'(exec_valid), 0);
            run = ~run;
            tick();
        end
        rst = 1'b1; run = 1'b0;
        tick();
        check("halt_clear", int'(halted), 0);
        check("halt_clear_pc", int'(pc), 0);

        // run dropped during EXEC
        rst = 1'b0; mem[0] = 8'h08; exec_ready = 1'b0; run = 1'b1;
        tick(); tick(); tick();
        check("drop_valid", int'(exec_valid), 1);
        run = 1'b0; exec_ready = 1'b1;
        tick();
        check("drop_pc_inc", int'(pc), 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("drop_idle_pc", int'(pc), 1);
            check("drop_idle_valid", int'(exec_valid), 0);
        end

        // Reset while exec_valid is high
        run = 1'b1; exec_ready = 1'b0;
        tick(); tick(); tick();
        check("rstmid_valid", int'(exec_valid), 1);
        rst = 1'b1;
        tick();
        check("rstmid_valid_drop", int'(exec_valid), 0);
        check("rstmid_pc", int'(pc), 0);
        rst = 1'b0;

`ifdef SINGLE_STEP_EN
        // Two step pulses retire exactly two instructions
        rst = 1'b1; step = 1'b0; exec_ready = 1'b1;
        foreach (mem[i]) mem[i] = 8'h01;
        tick();
        rst = 1'b0; seen = 0;
        for (int c = 0; c < 40; c++) begin
            step = (c == 10 || c == 20);
            tick();
            if (exec_valid && exec_ready) seen++;
        end
        check("step_retired", seen, 2);
        step = 1'b1;
`endif

        // Random programs: odd addresses hold datapath ops, even ones may branch to odd targets
        for (int p = 0; p < 6; p++) begin
            for (int a = 0; a < 16; a++) begin
                if (a % 2 == 0 && ($urandom % 2) == 1) begin
                    mem[a] = {(($urandom % 2) == 1) ? 4'hB : 4'hC, 3'($urandom), 1'b1};
                end else begin
                    op = int'($urandom_range(0, 12));
                    if (op > 10) op = op + 2;
                    mem[a] = {4'(op), 4'($urandom)};
                end
            end
            m_zero = 1'($urandom); zero_flag = m_zero;
            rst = 1'b1; run = 1'b1;
            tick();
            rst = 1'b0; m_pc = 4'd0; seen = 0; pend = 1'b0;
            for (int c = 0; c < 400 && seen < 12; c++) begin
                tick();
                if (pend) begin
                    check("rand_pc_inc", int'(pc), int'(exp_pc_next));
                    pend = 1'b0;
                end
                rdy = (($urandom % 4) != 0);
                exec_ready = rdy;
                if (exec_valid && rdy) begin
                    next_exec(e_pc, e_ins);
                    check("rand_opcode", int'(opcode), int'(e_ins[7:4]));
                    check("rand_operand", int'(operand), int'(e_ins[3:0]));
                    check("rand_pc", int'(pc), int'(e_pc));
                    exp_pc_next = e_pc + 4'd1;
                    pend = 1'b1;
                    seen++;
                end
            end
            check("rand_handshakes", seen, 12);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction fetch/decode sequencer for the 4-bit microprocessor.
- Owns the program counter and drives the address of the combinational 4-to-8 program store.
- Latches the 8-bit instruction and splits it into opcode (high nibble) and operand (low nibble).
- Resolves control-flow opcodes itself and hands every other instruction to the execute datapath through a valid/ready handshake.

Parameters:
- AW, 4: program address / PC width.
- DW, 8: instruction width.
- OPW, 4: opcode width; operand width is DW-OPW.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  level; 1 permits fetching new instructions.
- mem_addr  out  AW  address to program store; always equals pc.
- mem_data  in  DW  instruction from program store, combinational w.r.t. mem_addr.
- opcode  out  OPW  ir[7:4].
- operand  out  DW-OPW  ir[3:0].
- exec_valid  out  1  instruction presented to datapath.
- exec_ready  in  1  datapath accepts/completes the presented instruction.
- zero_flag  in  1  datapath zero flag, sampled in DECODE.
- pc  out  AW  current program counter.
- halted  out  1  HLT executed.
- step  in  1  single-step pulse (only with SINGLE_STEP_EN).

Behaviour:
- Clock/reset: one clock domain, clk. Reset rst is synchronous, active-high, and has priority over everything including mid-handshake.
- Reset values: state=IDLE, pc=0, ir=0, exec_valid=0, halted=0; hence opcode=0, operand=0, mem_addr=0.
- Opcodes, as package constants:
  - JMP=4'hB
  - JZ=4'hC
  - HLT=4'hF
  - all others are datapath ops.
- IDLE: run=1 -> FETCH; else stay.
- FETCH: ir <= mem_data (addressed by pc this cycle) -> DECODE.
- DECODE, one cycle, acting on ir:
  - JMP: pc <= operand -> FETCH; no exec_valid.
  - JZ: zero_flag=1 -> pc <= operand, else pc <= pc+1 -> FETCH.
  - HLT: -> HALT.
  - other: -> EXEC.
- EXEC:
  - exec_valid=1, held stable with opcode/operand until exec_ready=1.
  - On the handshake cycle: pc <= pc+1; next state FETCH if run=1, else IDLE.
  - exec_valid drops the cycle after the handshake.
- HALT: halted=1, pc frozen, exec_valid=0; exits only via rst.
- run=0 mid-instruction: the current instruction completes (DECODE/EXEC finish), then IDLE. run has no effect in HALT.
- PC arithmetic: modulo 2^AW; pc=15 +1 -> 0. Jump targets carry no range check.
- Latency:
  - datapath instruction: 3 cycles minimum (FETCH, DECODE, EXEC with ready=1).
  - JMP/JZ: 2 cycles.
- exec_ready outside EXEC is ignored.
- zero_flag is sampled only in DECODE.

Optional Feature:
- Macro: SINGLE_STEP_EN.
- Defined:
  - IDLE->FETCH and EXEC->FETCH additionally require step=1 in that cycle; otherwise go to/stay in IDLE.
  - Exactly one instruction per step pulse; a held step=1 runs freely.
  - A JMP/JZ consumes its own step.
- Undefined: step port absent; behaviour as above.

Decomposition:
- Shared package: opcode constants (OP_JMP, OP_JZ, OP_HLT), state enum (IDLE, FETCH, DECODE, EXEC, HALT), AW/DW/OPW defaults.
- Sub-module pc_reg: holds pc, with load (target) and increment controls, wrap-around modulo 2^AW, and sync reset to 0.
- FSM and IR stay in the top.

Test Plan:
- Reset/start:
  - Stimulus: rst=1 for 2 cycles, then run=1, exec_ready=1; mem[0]=8'h08.
  - Required: pc=0, exec_valid=0 during reset; exec_valid=1 with opcode=0, operand=8 on cycle 3 after run; pc=1 the following cycle.
- Backpressure:
  - Stimulus: mem[1]=8'h19, exec_ready held 0 for 5 cycles.
  - Required: exec_valid stays 1, opcode=1/operand=9 stable, pc stays 1; pc=2 one cycle after ready rises.
- Jump and wrap:
  - Stimulus: mem[9]=8'hB3.
  - Required: pc=3 two cycles after fetching address 9, no exec_valid pulse.
  - Stimulus: mem[15]=8'h10 executed.
  - Required: pc wraps to 0.
- Conditional:
  - Stimulus: JZ 8'hC5 with zero_flag=1.
  - Required: pc=5.
  - Stimulus: same instruction with zero_flag=0 at pc=4.
  - Required: pc=5 via increment.
  - Stimulus: JZ 8'hC2 at pc=7, zero_flag=0.
  - Required: pc=8.
- Halt/run:
  - Stimulus: 8'hF0.
  - Required: halted=1 permanently, pc frozen, run toggles ignored; rst clears to pc=0.
  - Stimulus: run dropped during EXEC.
  - Required: handshake completes, pc increments, state IDLE.
- Single-step (SINGLE_STEP_EN):
  - Stimulus: run=1, step pulses at cycles 10 and 20.
  - Required: exactly two instructions retire.
  - Stimulus: rst asserted while exec_valid=1.
  - Required: exec_valid=0 on the next cycle.
